// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC0809 scan controller.
package adc_pkg;

  localparam int CH_MAX = 32;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SEL     = 4'd1,
    ST_ALE     = 4'd2,
    ST_START_P = 4'd3,
    ST_START_N = 4'd4,
    ST_WAIT_L  = 4'd5,
    ST_WAIT_H  = 4'd6,
    ST_OE      = 4'd7,
    ST_CAPT    = 4'd8
  } state_t;

  // Lowest enabled channel at or after 'from', wrapping modulo n.
  function automatic int unsigned next_chan(input logic [CH_MAX-1:0] mask,
                                            input int unsigned from,
                                            input int unsigned n);
    int unsigned idx;
    logic        found;
    found     = 1'b0;
    next_chan = from;
    for (int unsigned i = 0; i < CH_MAX; i++) begin
      idx = from + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && mask[idx[$clog2(CH_MAX)-1:0]]) begin
        found     = 1'b1;
        next_chan = idx;
      end
    end
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ADC clock divider: 50% duty clock plus a one-cycle tick on each rising edge.
module adc_clk_div #(
  parameter int CLK_DIV = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic adc_clk_o,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  // Outputs are registered from the next count so they line up with cnt_q.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_q     <= '0;
      adc_clk_o <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adc_clk_o <= (cnt_d < HALF);
      tick      <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for ADC0809-class converters (ALE/START/EOC/OE).
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CH_NUM  = 8,
  parameter int CH_W    = 3,
  parameter int CLK_DIV = 128,
  parameter int EOC_TMO = 1023,
  parameter int OE_HOLD = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_en,
  input  logic              one_shot,
  input  logic [CH_NUM-1:0] ch_mask,
  output logic              adc_clk_o,
  output logic [CH_W-1:0]   addr,
  output logic              ale,
  output logic              start,
  input  logic              eoc,
  output logic              oe,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data,
  output logic [CH_W-1:0]   data_ch,
  output logic              data_en,
  output logic              timeout_err,
  output logic              busy
);

  localparam int            TW       = $clog2(EOC_TMO + 1);
  localparam int            OW       = $clog2(OE_HOLD + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(EOC_TMO - 1);
  localparam logic [OW-1:0] OE_LAST  = OW'(OE_HOLD - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);

  state_t            state_q, state_d;
  logic              tick;
  logic              eoc_p0, eoc_p1;
  logic              adc_en_q;
  logic              pass_done_q;
  logic              terr_q;
  logic [CH_W-1:0]   cur_q, nxt_q;
  logic [TW-1:0]     tmo_cnt_q;
  logic [OW-1:0]     oe_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]   data_ch_q;

  logic              adc_en_rise;
  logic [CH_W-1:0]   nxt_eff;
  logic              done_eff;
  logic [CH_NUM-1:0] above_cur;
  logic              last_ch;
  logic [CH_W-1:0]   cur_inc;
  logic              sel_go, tmo_hit, capture, chan_end;

  adc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .run       (adc_en | busy),
    .adc_clk_o (adc_clk_o),
    .tick      (tick)
  );

  // A fresh adc_en edge restarts the one-shot pass from channel 0 in the same cycle.
  assign adc_en_rise = adc_en & ~adc_en_q;
  assign nxt_eff     = adc_en_rise ? '0 : nxt_q;
  assign done_eff    = adc_en_rise ? 1'b0 : pass_done_q;
  assign above_cur   = ch_mask >> cur_q;
  assign last_ch     = (above_cur[CH_NUM-1:1] == '0);
  assign cur_inc     = (cur_q == CH_LAST) ? '0 : cur_q + 1'b1;
  assign chan_end    = (state_q == ST_CAPT) | tmo_hit;

  always_comb begin
    state_d = state_q;
    sel_go  = 1'b0;
    tmo_hit = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick && adc_en && (ch_mask != '0) && !(one_shot && done_eff)) begin
          sel_go  = 1'b1;
          state_d = ST_SEL;
        end
      end
      ST_SEL:     if (tick) state_d = ST_ALE;
      ST_ALE:     if (tick) state_d = ST_START_P;
      ST_START_P: if (tick) state_d = ST_START_N;
      ST_START_N: if (tick) state_d = ST_WAIT_L;
      ST_WAIT_L: begin
        if (tick) begin
          if (!eoc_p1) begin
            state_d = ST_WAIT_H;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_H: begin
        if (tick) begin
          if (eoc_p1) begin
            state_d = ST_OE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_OE: begin
        if (oe_cnt_q == OE_LAST) begin
          capture = 1'b1;
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      eoc_p0      <= 1'b0;
      eoc_p1      <= 1'b0;
      adc_en_q    <= 1'b0;
      pass_done_q <= 1'b0;
      terr_q      <= 1'b0;
      cur_q       <= '0;
      nxt_q       <= '0;
      tmo_cnt_q   <= '0;
      oe_cnt_q    <= '0;
      data_q      <= '0;
      data_ch_q   <= '0;
    end else begin
      state_q  <= state_d;
      eoc_p0   <= eoc;
      eoc_p1   <= eoc_p0;
      adc_en_q <= adc_en;
      terr_q   <= tmo_hit;

      if (sel_go) cur_q <= CH_W'(next_chan(CH_MAX'(ch_mask), 32'(nxt_eff), CH_NUM));

      if (state_d != state_q)
        tmo_cnt_q <= '0;
      else if (tick && ((state_q == ST_WAIT_L) || (state_q == ST_WAIT_H)))
        tmo_cnt_q <= tmo_cnt_q + 1'b1;

      if (state_q == ST_OE) oe_cnt_q <= oe_cnt_q + 1'b1;
      else                  oe_cnt_q <= '0;

      if (capture) begin
        data_q    <= data_in;
        data_ch_q <= cur_q;
      end

      // Finishing a channel (delivered or timed out) advances the scan pointer.
      if (chan_end) begin
        nxt_q <= cur_inc;
        if (one_shot && last_ch) pass_done_q <= 1'b1;
      end

      if (adc_en_rise) begin
        nxt_q       <= '0;
        pass_done_q <= 1'b0;
      end
    end
  end

  assign addr        = cur_q;
  assign ale         = (state_q == ST_ALE);
  assign start       = (state_q == ST_START_P);
  assign oe          = (state_q == ST_OE);
  assign data_en     = (state_q == ST_CAPT);
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = terr_q;
  assign data        = data_q;
  assign data_ch     = data_ch_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural ADC0809 model.
module tb_adc_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_en;
  logic       one_shot;
  logic [7:0] ch_mask;
  logic       adc_clk_o;
  logic [2:0] addr;
  logic       ale, start, eoc, oe;
  logic [7:0] data_in, data;
  logic [2:0] data_ch;
  logic       data_en, timeout_err, busy;

  adc_scan_ctrl #(
    .DATA_W(8), .CH_NUM(8), .CH_W(3), .CLK_DIV(4), .EOC_TMO(16), .OE_HOLD(3)
  ) dut (
    .clk(clk), .rst(rst), .adc_en(adc_en), .one_shot(one_shot), .ch_mask(ch_mask),
    .adc_clk_o(adc_clk_o), .addr(addr), .ale(ale), .start(start), .eoc(eoc),
    .oe(oe), .data_in(data_in), .data(data), .data_ch(data_ch), .data_en(data_en),
    .timeout_err(timeout_err), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] ch_val [8] = '{8'hA5, 8'h11, 8'h22, 8'h3C, 8'h44, 8'h5A, 8'h66, 8'h7E};

  // ADC model: latches addr on ALE, EOC low from START fall, high after 8 ADC clocks.
  logic eoc_stuck = 1'b0;
  int   m_conv = 0;
  logic [2:0] m_ch = 3'd0;
  logic m_prev_start = 1'b0, m_prev_aclk = 1'b0;
  initial begin
    eoc = 1'b1;
    data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (ale === 1'b1) m_ch = addr;
      if (m_prev_start && (start === 1'b0)) begin
        m_conv = 8;
        eoc = 1'b0;
      end else if ((m_conv > 0) && (adc_clk_o === 1'b1) && !m_prev_aclk) begin
        m_conv = m_conv - 1;
        if (m_conv == 0) eoc = 1'b1;
      end
      if (eoc_stuck) eoc = 1'b1;
      data_in = (oe === 1'b1) ? ch_val[m_ch] : 8'h00;
      m_prev_start = (start === 1'b1);
      m_prev_aclk  = (adc_clk_o === 1'b1);
    end
  end

  // Output monitor: sample log and event counters.
  logic [2:0] s_ch [$];
  logic [7:0] s_dat [$];
  int cyc = 0, ale_run = 0, ale_len = 0, start_run = 0, start_len = 0;
  int ale_rises = 0, sfall_cyc = 0, tmo_pulses = 0, tmo_cyc = 0, tmo_hi = 0;
  int busy_cyc = 0, aclk_hi = 0;
  logic ale_prev = 1'b0, start_prev = 1'b0, tmo_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (data_en === 1'b1) begin
        s_ch.push_back(data_ch);
        s_dat.push_back(data);
      end
      if (ale === 1'b1) ale_run++;
      else begin
        if (ale_run != 0) ale_len = ale_run;
        ale_run = 0;
      end
      if ((ale === 1'b1) && !ale_prev) ale_rises++;
      if (start === 1'b1) start_run++;
      else begin
        if (start_run != 0) start_len = start_run;
        start_run = 0;
      end
      if ((start !== 1'b1) && start_prev) sfall_cyc = cyc;
      if (timeout_err === 1'b1) begin
        tmo_hi++;
        if (!tmo_prev) begin
          tmo_pulses++;
          tmo_cyc = cyc;
        end
      end
      if (busy === 1'b1) busy_cyc++;
      if (adc_clk_o === 1'b1) aclk_hi++;
      ale_prev   = (ale === 1'b1);
      start_prev = (start === 1'b1);
      tmo_prev   = (timeout_err === 1'b1);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct packed {
    logic [7:0]      mask;
    logic [3:0]      n;
    logic [7:0][2:0] chs;   // chs[0] is the first expected channel
  } vec_t;

  vec_t vecs [6];
  int base, base2, k, snap_a, snap_b, snap_c;
  logic [2:0] exp5 [5] = '{3'd0, 3'd3, 3'd5, 3'd0, 3'd3};
  logic [2:0] exp3 [3] = '{3'd3, 3'd7, 3'd7};

  initial begin
    vecs[0] = '{mask: 8'h01, n: 4'd1, chs: 24'd0};
    vecs[1] = '{mask: 8'h29, n: 4'd3, chs: {15'd0, 3'd5, 3'd3, 3'd0}};
    vecs[2] = '{mask: 8'h80, n: 4'd1, chs: {21'd0, 3'd7}};
    vecs[3] = '{mask: 8'h81, n: 4'd2, chs: {18'd0, 3'd7, 3'd0}};
    vecs[4] = '{mask: 8'h24, n: 4'd2, chs: {18'd0, 3'd5, 3'd2}};
    vecs[5] = '{mask: 8'hFF, n: 4'd8,
                chs: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};

    rst = 1'b1; adc_en = 1'b0; one_shot = 1'b0; ch_mask = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_adc_clk", adc_clk_o, 0);
    check("rst_addr", addr, 0);
    check("rst_ale", ale, 0);
    check("rst_start", start, 0);
    check("rst_oe", oe, 0);
    check("rst_data", data, 0);
    check("rst_data_ch", data_ch, 0);
    check("rst_data_en", data_en, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // One-shot passes over a set of masks.
    for (int v = 0; v < 6; v++) begin
      ch_mask = vecs[v].mask;
      one_shot = 1'b1;
      base = s_ch.size();
      adc_en = 1'b1;
      repeat (100 * int'(vecs[v].n) + 150) @(negedge clk);
      check($sformatf("v%0d_count", v), s_ch.size() - base, vecs[v].n);
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        if (base + i < s_ch.size()) begin
          check($sformatf("v%0d_ch%0d", v, i), s_ch[base+i], vecs[v].chs[i]);
          check($sformatf("v%0d_data%0d", v, i), s_dat[base+i], ch_val[vecs[v].chs[i]]);
        end
      end
      if (v == 0) begin
        check("ale_width", ale_len, 4);
        check("start_width", start_len, 4);
        check("data_hold", data, 8'hA5);
        check("data_en_idle", data_en, 0);
        check("oneshot_idle_busy", busy, 0);
      end
      adc_en = 1'b0;
      repeat (20) @(negedge clk);
    end

    // Continuous scan, then a mask change while ch3 is converting.
    pulse_rst();
    one_shot = 1'b0;
    ch_mask = 8'h29;
    base = s_ch.size();
    adc_en = 1'b1;
    k = 0;
    while ((s_ch.size() < base + 5) && (k < 800)) begin @(negedge clk); k++; end
    check("cont_five_samples", s_ch.size() >= base + 5, 1);
    for (int i = 0; i < 5; i++)
      if (base + i < s_ch.size()) check($sformatf("cont_ch%0d", i), s_ch[base+i], exp5[i]);
    k = 0;
    while (!((ale === 1'b1) && (addr === 3'd3)) && (k < 400)) begin @(negedge clk); k++; end
    check("cont_ch3_selected", (ale === 1'b1) && (addr === 3'd3), 1);
    ch_mask = 8'h80;
    base = s_ch.size();
    k = 0;
    while ((s_ch.size() < base + 3) && (k < 600)) begin @(negedge clk); k++; end
    check("mask_chg_samples", s_ch.size() >= base + 3, 1);
    for (int i = 0; i < 3; i++)
      if (base + i < s_ch.size()) begin
        check($sformatf("mask_chg_ch%0d", i), s_ch[base+i], exp3[i]);
        check($sformatf("mask_chg_data%0d", i), s_dat[base+i], ch_val[exp3[i]]);
      end
    adc_en = 1'b0;
    repeat (200) @(negedge clk);

    // adc_en dropped while waiting for EOC high.
    pulse_rst();
    ch_mask = 8'h01;
    one_shot = 1'b0;
    base = s_ch.size();
    adc_en = 1'b1;
    k = 0;
    while ((m_conv != 4) && (k < 300)) begin @(negedge clk); k++; end
    check("drop_mid_conv_reached", m_conv, 4);
    adc_en = 1'b0;
    k = 0;
    while ((busy !== 1'b0) && (k < 300)) begin @(negedge clk); k++; end
    check("drop_busy_clear", busy, 0);
    check("drop_sample_count", s_ch.size() - base, 1);
    if (s_ch.size() > base) begin
      check("drop_ch", s_ch[base], 0);
      check("drop_data", s_dat[base], 8'hA5);
    end
    repeat (2) @(negedge clk);
    check("drop_adc_clk_low", adc_clk_o, 0);
    snap_a = ale_rises;
    snap_b = aclk_hi;
    repeat (100) @(negedge clk);
    check("drop_no_new_ale", ale_rises - snap_a, 0);
    check("drop_clk_stopped", aclk_hi - snap_b, 0);

    // EOC stuck high: timeout in WAIT_L, then move on to the next channel.
    pulse_rst();
    eoc_stuck = 1'b1;
    ch_mask = 8'h09;
    one_shot = 1'b0;
    base = s_ch.size();
    snap_a = tmo_pulses;
    snap_b = tmo_hi;
    adc_en = 1'b1;
    k = 0;
    while ((tmo_pulses == snap_a) && (k < 400)) begin @(negedge clk); k++; end
    check("tmo_seen", tmo_pulses - snap_a, 1);
    check("tmo_delay_after_start", tmo_cyc - sfall_cyc, 68);
    k = 0;
    while ((ale !== 1'b1) && (k < 100)) begin @(negedge clk); k++; end
    check("tmo_next_ale", ale, 1);
    check("tmo_next_ch", addr, 3);
    check("tmo_pulse_width", tmo_hi - snap_b, 1);
    check("tmo_no_data", s_ch.size() - base, 0);
    adc_en = 1'b0;
    eoc_stuck = 1'b0;
    pulse_rst();

    // Reset while oe is high on ch1; restart must begin at ch0.
    ch_mask = 8'h0B;
    one_shot = 1'b0;
    base = s_ch.size();
    adc_en = 1'b1;
    k = 0;
    while (!((oe === 1'b1) && (addr === 3'd1)) && (k < 400)) begin @(negedge clk); k++; end
    check("rst_oe_reached", (oe === 1'b1) && (addr === 3'd1), 1);
    base2 = s_ch.size();
    check("rst_oe_prior_samples", base2 - base, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_oe_oe", oe, 0);
    check("rst_oe_data_en", data_en, 0);
    check("rst_oe_busy", busy, 0);
    check("rst_oe_adc_clk", adc_clk_o, 0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while ((s_ch.size() <= base2) && (k < 300)) begin @(negedge clk); k++; end
    check("rst_restart_sample", s_ch.size() > base2, 1);
    if (s_ch.size() > base2) check("rst_restart_ch", s_ch[base2], 0);
    adc_en = 1'b0;
    pulse_rst();

    // Empty mask: nothing ever starts.
    ch_mask = 8'h00;
    adc_en = 1'b1;
    snap_a = busy_cyc;
    snap_c = ale_rises;
    repeat (1000) @(negedge clk);
    check("mask0_busy_cycles", busy_cyc - snap_a, 0);
    check("mask0_ale_rises", ale_rises - snap_c, 0);
    check("mask0_busy_now", busy, 0);
    adc_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
